dram_line_xfer: RTL

Line-transfer engine between the direct-mapped cache controller and the four-bank interleaved DRAM. It turns one 16-byte cache-line fill or writeback request into four sequential word accesses, one per bank (addr[3:2] = 0..3). It holds each access stable while the DRAM stalls and collects read data at a fixed latency. It returns the assembled line, or a write completion, as a single-cycle response.

---
 rtl/dram_line_xfer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dram_line_xfer.sv
// dram_line_xfer: splits one 16-byte cache-line fill or writeback into four
// single-word DRAM accesses (banks 0..3 in order). Each access is held while
// the DRAM stalls. Read data is captured at a fixed latency through a small
// tag delay line. A one-cycle response carries the assembled line and a sticky
// error flag.
module dram_line_xfer #(
  parameter int RD_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_wr,
  input  logic [31:0]  req_addr,
  input  logic [127:0] req_wdata,
  output logic         resp_valid,
  output logic [127:0] resp_rdata,
  output logic         resp_err,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_data_in,
  output logic         mem_wr,
  output logic         mem_rd,
  input  logic [31:0]  mem_data_out,
  input  logic         mem_stall,
  input  logic         mem_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_reg;
  state_t         state_next;

  logic [27:0]    base_reg;      // line address bits [31:4]
  logic           wr_reg;
  logic [127:0]   wdata_reg;
  logic [1:0]     k_reg;         // index of the word currently being issued
  logic           err_reg;       // sticky error over accepted accesses
  logic [127:0]   buf_reg;       // fill capture buffer

  // Read-tag delay line: stage RD_LATENCY-1 lines up with mem_data_out.
  logic [RD_LATENCY-1:0]      dl_valid_reg;
  logic [RD_LATENCY-1:0][1:0] dl_idx_reg;

  logic           req_accept;
  logic           word_accept;
  logic           cap_valid;
  logic [1:0]     cap_idx;

  // Low address bits select a byte within the line and are not needed.
  logic           addr_lsb_unused;
  assign addr_lsb_unused = ^req_addr[3:0];

  assign req_accept  = req_valid & (state_reg == IDLE);
  assign word_accept = (state_reg == ISSUE) & ~mem_stall;
  assign cap_valid   = dl_valid_reg[RD_LATENCY-1];
  assign cap_idx     = dl_idx_reg[RD_LATENCY-1];

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and all externally visible outputs.
  always_comb begin
    state_next  = state_reg;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    resp_err    = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // Everything here depends only on registered state, so it is
        // naturally stable for as long as the DRAM stalls.
        mem_addr    = {base_reg, k_reg, 2'b00};
        mem_data_in = wdata_reg[{k_reg, 5'b00000} +: 32];
        mem_rd      = ~wr_reg;
        mem_wr      = wr_reg;
        if (!mem_stall && (k_reg == 2'd3)) begin
          state_next = wr_reg ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (cap_valid && (cap_idx == 2'd3)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_rdata = buf_reg;   // stays zero for writebacks
        resp_err   = err_reg;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch, word counter, sticky error and read-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_reg  <= '0;
      wr_reg    <= 1'b0;
      wdata_reg <= '0;
      k_reg     <= 2'd0;
      err_reg   <= 1'b0;
      buf_reg   <= '0;
    end else begin
      if (req_accept) begin
        base_reg  <= req_addr[31:4];
        wr_reg    <= req_wr;
        wdata_reg <= req_wdata;
        k_reg     <= 2'd0;
        err_reg   <= 1'b0;
        buf_reg   <= '0;
      end
      if (word_accept) begin
        k_reg   <= k_reg + 2'd1;
        err_reg <= err_reg | mem_err;
      end
      if (cap_valid) begin
        buf_reg[{cap_idx, 5'b00000} +: 32] <= mem_data_out;
      end
    end
  end

  // Tag delay line: a read accepted in cycle c is captured in cycle c+RD_LATENCY,
  // independent of later stalls.
  generate
    for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_dl
      if (gi == 0) begin : g_head
        // First stage loads the tag of a read accepted this cycle.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            dl_valid_reg[0] <= 1'b0;
            dl_idx_reg[0]   <= 2'd0;
          end else begin
            dl_valid_reg[0] <= word_accept & ~wr_reg;
            dl_idx_reg[0]   <= k_reg;
          end
        end
      end else begin : g_tail
        // Later stages shift the tag one cycle each.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            dl_valid_reg[gi] <= 1'b0;
            dl_idx_reg[gi]   <= 2'd0;
          end else begin
            dl_valid_reg[gi] <= dl_valid_reg[gi-1];
            dl_idx_reg[gi]   <= dl_idx_reg[gi-1];
          end
        end
      end
    end
  endgenerate

endmodule
